// File: rtl/cv32e40px_x_result_buf.sv
// Coprocessor result buffer: queues X-interface results for RF write port B (optional bypass: CV32E40PX_X_RESULT_BYPASS_EN).
// Latency: push to RF write 1 cycle (0 cycles via bypass when empty and port B free).
// Backpressure: x_result_ready_o low while full; a head starved STARVE_LIMIT cycles raises stall_core_o.
module cv32e40px_x_result_buf #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_result_valid_i,
  output logic        x_result_ready_o,
  input  logic [3:0]  x_result_id_i,
  input  logic [31:0] x_result_data_i,
  input  logic [4:0]  x_result_rd_i,
  input  logic        x_result_we_i,
  input  logic        core_wb_we_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        sb_clr_valid_o,
  output logic [4:0]  sb_clr_addr_o,
  output logic        stall_core_o,
  output logic        id_err_o,
  output logic [3:0]  fifo_cnt_o
);

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } entry_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);
  localparam logic [3:0]       LIMIT_C  = 4'(STARVE_LIMIT);

  entry_t           mem [DEPTH];
  entry_t           in_ent;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [3:0]       cnt;
  logic [3:0]       cnt_d;
  logic [3:0]       starve_cnt;
  logic [3:0]       starve_d;
  logic [3:0]       exp_id;
  logic [1:0]       state;
  logic [1:0]       state_d;
  logic             push;
  logic             push_store;
  logic             bypass;
  logic             pop;
  logic             blocked;
  logic             head_writes;
  logic             byp_writes;
  logic [3:0]       unused_head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ent = {x_result_id_i, x_result_data_i, x_result_rd_i, x_result_we_i};
  assign head   = mem[rd_ptr];
  assign unused_head_id = head.id;

  // Ready comes from the registered count only, so a pop never frees a slot for a same-cycle push.
  assign x_result_ready_o = rst_i | (cnt != DEPTH_C);
  assign push             = x_result_valid_i & x_result_ready_o & ~rst_i;

`ifdef CV32E40PX_X_RESULT_BYPASS_EN
  assign bypass = push & (cnt == 4'd0) & ~core_wb_we_i;
`else
  assign bypass = 1'b0;
`endif

  assign push_store = push & ~bypass;
  assign pop        = (cnt != 4'd0) & ~core_wb_we_i & ~rst_i;
  assign blocked    = (cnt != 4'd0) & core_wb_we_i;
  assign cnt_d      = cnt + {3'b000, push_store} - {3'b000, pop};

  // Entries that target x0 or do not write still drain, just without an RF write.
  assign head_writes    = pop & head.we & (head.rd != 5'd0);
  assign byp_writes     = bypass & in_ent.we & (in_ent.rd != 5'd0);
  assign rf_we_o        = head_writes | byp_writes;
  assign sb_clr_valid_o = rf_we_o;
  assign sb_clr_addr_o  = rf_we_o ? rf_waddr_o : 5'd0;

  always_comb begin
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (bypass) begin
      rf_waddr_o = in_ent.rd;
      rf_wdata_o = in_ent.data;
    end else if ((cnt != 4'd0) && !rst_i) begin
      rf_waddr_o = head.rd;
      rf_wdata_o = head.data;
    end
  end

  always_comb begin
    starve_d = starve_cnt;
    if (pop) begin
      starve_d = 4'd0;
    end else if (blocked && (starve_cnt != 4'hF)) begin
      starve_d = starve_cnt + 4'd1;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (push_store) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pop && (cnt_d == 4'd0)) begin
          state_d = ST_IDLE;
        end else if (blocked && (starve_d >= LIMIT_C)) begin
          state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        if (pop) state_d = (cnt_d == 4'd0) ? ST_IDLE : ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= 4'd0;
      starve_cnt <= 4'd0;
      exp_id     <= 4'd0;
      id_err_o   <= 1'b0;
      state      <= ST_IDLE;
    end else begin
      if (push_store) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)        rd_ptr <= ptr_inc(rd_ptr);
      cnt        <= cnt_d;
      starve_cnt <= starve_d;
      state      <= state_d;
      // Bypassed results still consume an id slot.
      if (push) begin
        exp_id <= exp_id + 4'd1;
        if (x_result_id_i != exp_id) id_err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_store) mem[wr_ptr] <= in_ent;
  end

  assign stall_core_o = (state == ST_FORCE);
  assign fifo_cnt_o   = cnt;

endmodule

// File: tb/tb_cv32e40px_x_result_buf.sv
// Scoreboard bench for cv32e40px_x_result_buf: directed scenarios then randomized traffic.
`timescale 1ns/1ps
module tb_cv32e40px_x_result_buf;

  localparam int DEPTH  = 2;
  localparam int STARVE = 4;
`ifdef CV32E40PX_X_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  bit          clk = 1'b0;
  logic        rst;
  logic        x_valid;
  logic        x_ready;
  logic [3:0]  x_id;
  logic [31:0] x_data;
  logic [4:0]  x_rd;
  logic        x_we;
  logic        core_wb_we;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        sb_clr_valid;
  logic [4:0]  sb_clr_addr;
  logic        stall_core;
  logic        id_err;
  logic [3:0]  fifo_cnt;

  always #5 clk = ~clk;

  cv32e40px_x_result_buf #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .x_result_valid_i (x_valid),
    .x_result_ready_o (x_ready),
    .x_result_id_i    (x_id),
    .x_result_data_i  (x_data),
    .x_result_rd_i    (x_rd),
    .x_result_we_i    (x_we),
    .core_wb_we_i     (core_wb_we),
    .rf_we_o          (rf_we),
    .rf_waddr_o       (rf_waddr),
    .rf_wdata_o       (rf_wdata),
    .sb_clr_valid_o   (sb_clr_valid),
    .sb_clr_addr_o    (sb_clr_addr),
    .stall_core_o     (stall_core),
    .id_err_o         (id_err),
    .fifo_cnt_o       (fifo_cnt)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
  } ent_t;

  // Reference model: a queue of buffered results plus simple id and starvation bookkeeping.
  ent_t       exp_q[$];
  ent_t       pend;
  ent_t       cur_ent;
  bit         pend_vld   = 1'b0;
  bit         pend_err   = 1'b0;
  bit         cur_byp    = 1'b0;
  bit         last_rst   = 1'b0;
  bit         mon_en     = 1'b0;
  bit [3:0]   exp_id     = 4'd0;
  bit         id_err_exp = 1'b0;
  int         blocked_cycles = 0;
  bit         forcing    = 1'b0;
  int         n_tests    = 0;
  int         n_fail     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; accepted results become expected entries from the following cycle on.
  task automatic cycle(input logic v, input logic [3:0] id, input logic [31:0] d,
                       input logic [4:0] rd, input logic we, input logic wb, input logic r);
    @(posedge clk);
    #1;
    if (pend_vld) begin
      exp_q.push_back(pend);
      pend_vld = 1'b0;
    end
    if (pend_err) begin
      id_err_exp = 1'b1;
      pend_err   = 1'b0;
    end
    if (last_rst) begin
      exp_id     = 4'd0;
      id_err_exp = 1'b0;
    end
    rst        = r;
    x_valid    = v;
    x_id       = id;
    x_data     = d;
    x_rd       = rd;
    x_we       = we;
    core_wb_we = wb;
    cur_byp    = 1'b0;
    last_rst   = r;
    if (!r && v && (exp_q.size() != DEPTH)) begin
      if (id != exp_id) pend_err = 1'b1;
      exp_id = exp_id + 4'd1;
      if (BYP && (exp_q.size() == 0) && !wb) begin
        cur_byp = 1'b1;
        cur_ent = '{id: id, data: d, rd: rd, we: we};
      end else begin
        pend     = '{id: id, data: d, rd: rd, we: we};
        pend_vld = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic wb, input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, wb, 1'b0);
  endtask

  ent_t        m_h;
  bit          m_pop;
  bit          m_we;
  logic [4:0]  m_a;
  logic [31:0] m_d;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("fifo_cnt", 32'(fifo_cnt), 32'(exp_q.size()));
      chk("ready", 32'(x_ready), 32'(rst || (exp_q.size() != DEPTH)));
      chk("stall", 32'(stall_core), 32'(forcing));
      chk("id_err", 32'(id_err), 32'(id_err_exp));
      m_pop = !rst && (exp_q.size() != 0) && !core_wb_we;
      m_we  = 1'b0;
      m_a   = 5'd0;
      m_d   = 32'd0;
      if (rst) begin
        m_we = 1'b0;
      end else if (m_pop) begin
        m_h  = exp_q[0];
        m_we = m_h.we && (m_h.rd != 5'd0);
        m_a  = m_h.rd;
        m_d  = m_h.data;
      end else if (cur_byp) begin
        m_we = cur_ent.we && (cur_ent.rd != 5'd0);
        m_a  = cur_ent.rd;
        m_d  = cur_ent.data;
      end else if (exp_q.size() != 0) begin
        m_a = exp_q[0].rd;
        m_d = exp_q[0].data;
      end
      chk("rf_we", 32'(rf_we), 32'(m_we));
      chk("sb_clr_valid", 32'(sb_clr_valid), 32'(m_we));
      chk("rf_waddr", 32'(rf_waddr), 32'(m_a));
      chk("rf_wdata", rf_wdata, m_d);
      if (m_we) chk("sb_clr_addr", 32'(sb_clr_addr), 32'(m_a));
      if (rst) begin
        exp_q.delete();
        blocked_cycles = 0;
        forcing        = 1'b0;
      end else if (m_pop) begin
        void'(exp_q.pop_front());
        blocked_cycles = 0;
        forcing        = 1'b0;
      end else if ((exp_q.size() != 0) && core_wb_we) begin
        blocked_cycles++;
        if (blocked_cycles >= STARVE) forcing = 1'b1;
      end
    end
  end

  initial begin
    int          wb_pct;
    logic        r_rst;
    logic        r_v;
    logic        r_wb;
    logic        r_we;
    logic [3:0]  r_id;
    logic [4:0]  r_rd;
    logic [31:0] r_d;

    rst        = 1'b1;
    x_valid    = 1'b0;
    x_id       = 4'd0;
    x_data     = 32'd0;
    x_rd       = 5'd0;
    x_we       = 1'b0;
    core_wb_we = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    cycle(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);

    // First result lands in the RF one cycle after the push.
    cycle(1'b1, 4'd0, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 2);

    // Fill while the core owns port B; the third result is refused.
    cycle(1'b1, 4'd1, 32'h1111_0001, 5'd1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 4'd2, 32'h2222_0002, 5'd2, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 4'd3, 32'h3333_0003, 5'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b0, 3);

    // Starved head forces a stall; releasing port B drains it.
    cycle(1'b1, 4'd3, 32'h0BAD_F00D, 5'd9, 1'b1, 1'b1, 1'b0);
    idle(1'b1, 4);
    idle(1'b0, 2);

    // Results to x0 or without write enable drain silently.
    cycle(1'b1, 4'd4, 32'hAAAA_5555, 5'd0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd5, 32'h5555_AAAA, 5'd7, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 2);

    // Out-of-order id sets a sticky error; both results are still written.
    cycle(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 4'd0, 32'h0000_00A0, 5'd10, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 4'd2, 32'h0000_00A2, 5'd11, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 3);

    // Reset with two entries buffered discards them.
    cycle(1'b1, 4'd2, 32'h0000_00B0, 5'd12, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 4'd3, 32'h0000_00B1, 5'd13, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 3);

    for (int seg = 0; seg < 6; seg++) begin
      wb_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 85);
      for (int i = 0; i < 500; i++) begin
        r_rst = ($urandom_range(0, 199) == 0);
        r_v   = ($urandom_range(0, 99) < 60);
        r_wb  = ($urandom_range(0, 99) < wb_pct);
        r_we  = ($urandom_range(0, 4) != 0);
        r_id  = ($urandom_range(0, 19) == 0) ? 4'($urandom) : exp_id;
        r_rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        r_d   = $urandom;
        cycle(r_v, r_id, r_d, r_rd, r_we, r_wb, r_rst);
      end
    end
    idle(1'b0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
